// File: rtl/lsu_dm.sv
// Load/store unit between the RV32I execute stage and a word-organised data
// memory with asynchronous read and a synchronous write.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake (one request in flight)
//   req_we, req_funct3, req_addr,
//   req_wdata                       byte-addressed load/store request
//   resp_valid, resp_err,
//   resp_rdata                      one-cycle completion pulse, error, load data
//   dm_we, dm_addres, dm_wd, dm_rd  word port of the data memory
module lsu_dm #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addres,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd
);

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_RMW_READ  = 3'd3;
    localparam logic [2:0] S_RMW_WRITE = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [2:0]        state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              req_legal;
    logic              req_misal;
    logic              req_err;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_value;
    logic [DATA_W-1:0] merged;

    // Bits above the word index are deliberately ignored (address aliasing).
    logic unused_addr;
    assign unused_addr = ^req_addr;

    assign accept = (state_q == S_IDLE) && req_valid;

    // Request legality and alignment, evaluated on the raw request.
    always_comb begin
        req_legal = 1'b0;
        req_misal = 1'b0;
        if (req_we) begin
            req_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
        end else begin
            req_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W)
                     || (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
        end
        if (req_funct3[1:0] == 2'b01) begin
            req_misal = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            req_misal = (req_addr[1:0] != 2'b00);
        end
        req_err = !req_legal || req_misal;
    end

    // Lane extraction and sign/zero extension of the memory read word.
    always_comb begin
        ld_byte  = dm_rd[{off_q, 3'b000} +: 8];
        ld_half  = dm_rd[{off_q[1], 4'b0000} +: 16];
        ld_value = '0;
        case (funct3_q)
            F3_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_value = {24'h000000, ld_byte};
            F3_H:    ld_value = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_value = {16'h0000, ld_half};
            F3_W:    ld_value = dm_rd;
            default: ld_value = '0;
        endcase
    end

    // Sub-word store merge into the word captured during RMW_READ.
    always_comb begin
        merged = buf_q;
        if (funct3_q == F3_B) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    idx_d    = req_addr[ADDR_W+1:2];
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    if (req_we || req_err) begin
                        rdata_d = '0;
                    end
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_READ;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = ld_value;
                state_d = S_RESP;
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RMW_READ: begin
                buf_d   = dm_rd;
                state_d = S_RMW_WRITE;
            end
            S_RMW_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            off_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = rdata_q;

    // rst_n gates the write strobe so a reset edge can never commit a write.
    assign dm_we     = ((state_q == S_WRITE) || (state_q == S_RMW_WRITE)) && rst_n;
    assign dm_addres = (state_q == S_IDLE) ? '0 : idx_q;

    always_comb begin
        dm_wd = '0;
        if (state_q == S_WRITE) begin
            dm_wd = wdata_q;
        end else if (state_q == S_RMW_WRITE) begin
            dm_wd = merged;
        end
    end

endmodule

// File: doc/lsu_dm.md
# lsu_dm

Load/store unit sitting between the RV32I execute stage and the word-organised data memory `DM`. It accepts one byte-addressed load or store at a time. It checks alignment. It translates the request into word accesses on the `DM` port: `clk`, `we`, `addres`, `wd`, `rd`, with asynchronous read and a write on the rising `clk` edge when `we`=1. Sub-word stores (SB/SH) are performed as read-modify-write; loads are lane-extracted and sign/zero-extended.

## Interface
Parameters:
- `ADDR_W`, 16: width of the `DM` word address (`dm_addres`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; the request is accepted on an edge where `req_valid`&&`req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from the low byte/half/word.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  misaligned or illegal funct3; qualified by `resp_valid`.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `dm_we`  out  1  to `DM.we`.
- `dm_addres`  out  ADDR_W  to `DM.addres` (word index).
- `dm_wd`  out  32  to `DM.wd`.
- `dm_rd`  in  32  from `DM.rd`, combinational read.

## Operation
- States: IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, RESP.
- **IDLE:** `req_ready`=1. On accept, latch `we`, `funct3`, `addr`, `wdata`. The word index is `req_addr[ADDR_W+1:2]`; higher address bits are ignored.
- **Error check at accept:**
  - LH/LHU/SH require `addr[0]`=0.
  - LW/SW require `addr[1:0]`=0.
  - Any unlisted funct3 is illegal.
  - On error, go to RESP with `resp_err`=1. No `DM` access is made.
- **Next state from IDLE:** load → LOAD; SW → WRITE; SB/SH → RMW_READ.
- **LOAD:** drive `dm_addres`, then register the extracted value into `resp_rdata`. Go to RESP.
  - Lanes are little-endian: byte n = bits [8n+7:8n], with n = `addr[1:0]`.
  - Half lane is `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **WRITE:** `dm_we`=1, `dm_wd`=`wdata`. Go to RESP.
- **RMW_READ:** register `dm_rd` into the merge buffer. Go to RMW_WRITE.
- **RMW_WRITE:** `dm_we`=1, `dm_wd` = buffer with the selected byte/half lane replaced by `wdata[7:0]`/`wdata[15:0]`. Go to RESP.
- **RESP:** `resp_valid`=1, `req_ready`=0. Go to IDLE.
- **`DM` port outputs:**
  - `dm_addres` equals the latched word index in every non-IDLE state and 0 in IDLE.
  - `dm_wd` is 0 outside the write states.
  - `dm_we` = (state ∈ {WRITE, RMW_WRITE}) && `rst_n`, decoded combinationally. The `rst_n` term guarantees that reset suppresses a write in progress.
- `resp_rdata` is registered and holds its value until the next response. It is cleared to 0 at the start of every store or error request.

## Timing
- Edge E0 = accept edge. Cycle k is the cycle after edge Ek-1.
- **Latency (`resp_valid` high during):**
  - error: cycle 1.
  - load: cycle 2 (LOAD in cycle 1).
  - SW: cycle 2, memory written at E1.
  - SB/SH: cycle 3, RMW_READ in cycle 1, memory written at E2.
- `req_ready` is 0 from cycle 1 until the unit returns to IDLE. Back-to-back requests are therefore spaced by (latency + 1) cycles. `req_valid` held high is not accepted while busy.
- **Reset:** an edge with `rst_n`=0 forces IDLE regardless of state. Reset values:
  - `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `dm_we`=0, `dm_addres`=0, `dm_wd`=0.
  - No `DM` write occurs on any edge where `rst_n`=0, including mid-RMW.
- **Wrap-around:** word index beyond 2^ADDR_W−1 aliases modulo 2^ADDR_W; this is not an error.

## Test plan
- SW addr 0x28 data 0x12345678 → `dm_we`=1 with `dm_addres`=10 in cycle 1, `resp_valid` in cycle 2. Then LW 0x28 → `resp_rdata`=0x12345678 in cycle 2, `resp_err`=0.
- SB 0x29 data 0xFFFFFFAB → word 10 = 0x1234AB78, `resp_valid` in cycle 3. Then LB 0x29 → 0xFFFFFFAB; LBU 0x29 → 0x000000AB.
- SH 0x2A data 0x8001 → word 10 = 0x8001AB78. Then LH 0x2A → 0xFFFF8001; LHU 0x2A → 0x00008001; LB 0x28 → 0x00000078.
- LW 0x2A, SH 0x2B, and load funct3 011 → `resp_err`=1, `resp_rdata`=0 in cycle 1, `dm_we` never high. A following LW 0x28 still returns 0x8001AB78.
- SB 0x28 data 0x00 with `rst_n`=0 during RMW_WRITE → `dm_we`=0 on that edge, next cycle `req_ready`=1 and `resp_valid`=0, and word 10 is unchanged (0x8001AB78).
- `req_valid` held high for SB then LW → `req_ready`=0 for cycles 1–3, and the LW is accepted at E4. The LW response returns the merged SB data.
